// File: rtl/branch_resolve_unit_pkg.sv
// br_pkg: shared definitions for the decode-stage branch resolve unit.
//   OP_BEQ / OP_BNE : primary opcodes of the two resolved branch types
//   br_ctx_t        : IF/ID branch context {valid, pc4, pred}
//   BR_PC_W         : default PC width (width of br_ctx_t.pc4)
//   BR_CNT_W        : default performance counter width
package br_pkg;

   localparam int BR_PC_W  = 32;
   localparam int BR_CNT_W = 16;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   typedef struct packed {
      logic               valid;
      logic [BR_PC_W-1:0] pc4;
      logic               pred;
   } br_ctx_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : count enable, sampled on the rising edge
//   cnt   : current count
module sat_counter
   import br_pkg::*;
#(
   parameter int W = BR_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds the IF/ID branch context and resolves beq/bne
// in ID with zero latency. Produces the predictor training pair (B, PreWrong),
// the fetch flush with its corrected PC, and saturating perf counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : pipeline stall, freezes the context and resolution
//   if_valid/if_pc/if_BrPre : IF instruction valid, PC and taken prediction
//   id_beq/id_bne         : ID decode bits (beq wins if both set)
//   rs_data/rt_data       : forwarded compare operands
//   id_imm                : signed word offset of the branch
//   B, PreWrong           : branch resolving / mispredicted, to PredictionUnit
//   flush, redirect_pc    : drop IF instruction and refetch from redirect_pc
//   br_cnt, miss_cnt      : resolved branch and misprediction counts
module branch_resolve_unit
   import br_pkg::*;
#(
   parameter int PC_W  = BR_PC_W,
   parameter int CNT_W = BR_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             if_valid,
   input  logic [PC_W-1:0]  if_pc,
   input  logic             if_BrPre,
   input  logic             id_beq,
   input  logic             id_bne,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic [15:0]      id_imm,
   output logic             B,
   output logic             PreWrong,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   br_ctx_t         ctx;
   logic            eq;
   logic            taken;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] target;

   // Flush outranks stall; pc4/pred are left alone on flush since a
   // cleared valid makes them irrelevant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctx <= '0;
      end else if (flush) begin
         ctx.valid <= 1'b0;
      end else if (!stall) begin
         ctx.valid <= if_valid;
         ctx.pc4   <= if_pc + PC_W'(4);
         ctx.pred  <= if_BrPre;
      end
   end

   always_comb begin
      eq = (rs_data == rt_data);
      if (id_beq) begin
         taken = eq;
      end else if (id_bne) begin
         taken = ~eq;
      end else begin
         taken = 1'b0;
      end
   end

   // Word offset to byte offset: sign-extend then shift left by two.
   assign offset = {{(PC_W-18){id_imm[15]}}, id_imm, 2'b00};
   assign target = ctx.pc4 + offset;

   // Gating with stall keeps a held branch from being counted or flushed
   // more than once; it resolves on the first free cycle.
   assign B           = ctx.valid & (id_beq | id_bne) & ~stall;
   assign PreWrong    = B & (taken ^ ctx.pred);
   assign flush       = PreWrong;
   assign redirect_pc = taken ? target : ctx.pc4;

   sat_counter #(.W(CNT_W)) u_br_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (B),
      .cnt   (br_cnt)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (PreWrong),
      .cnt   (miss_cnt)
   );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   localparam int PC_W  = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             stall;
   logic             if_valid;
   logic [PC_W-1:0]  if_pc;
   logic             if_BrPre;
   logic             id_beq;
   logic             id_bne;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic [15:0]      id_imm;
   logic             B;
   logic             PreWrong;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   branch_resolve_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_BrPre    (if_BrPre),
      .id_beq      (id_beq),
      .id_bne      (id_bne),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .id_imm      (id_imm),
      .B           (B),
      .PreWrong    (PreWrong),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .br_cnt      (br_cnt),
      .miss_cnt    (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1ns later, well away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] pc, input logic pred);
      if_valid = 1'b1;
      if_pc    = pc;
      if_BrPre = pred;
      step();
      if_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_BrPre = 1'b0;
      id_beq = 1'b0; id_bne = 1'b0; rs_data = '0; rt_data = '0; id_imm = '0;
      #12;
      chk("rst_B", {31'd0, B}, 32'd0);
      chk("rst_prewrong", {31'd0, PreWrong}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
      chk("rst_miss_cnt", {28'd0, miss_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // beq taken, predicted taken: correct, no flush
      load(32'h100, 1'b1);
      id_beq = 1'b1; rs_data = 32'd5; rt_data = 32'd5; id_imm = 16'd3;
      #1;
      chk("beq_ok_B", {31'd0, B}, 32'd1);
      chk("beq_ok_prewrong", {31'd0, PreWrong}, 32'd0);
      chk("beq_ok_flush", {31'd0, flush}, 32'd0);
      step();
      chk("beq_ok_br_cnt", {28'd0, br_cnt}, 32'd1);
      chk("beq_ok_miss_cnt", {28'd0, miss_cnt}, 32'd0);
      chk("invalid_id_B", {31'd0, B}, 32'd0);
      chk("invalid_id_flush", {31'd0, flush}, 32'd0);
      step();
      chk("invalid_hold_br_cnt", {28'd0, br_cnt}, 32'd1);

      // bne with equal operands predicted taken: mispredict, fall through
      load(32'h300, 1'b1);
      id_beq = 1'b0; id_bne = 1'b1; rs_data = 32'd7; rt_data = 32'd7;
      if_valid = 1'b1; if_pc = 32'h400; if_BrPre = 1'b0;
      #1;
      chk("bne_B", {31'd0, B}, 32'd1);
      chk("bne_prewrong", {31'd0, PreWrong}, 32'd1);
      chk("bne_flush", {31'd0, flush}, 32'd1);
      chk("bne_redirect", redirect_pc, 32'h304);
      step();
      chk("bne_dropped_B", {31'd0, B}, 32'd0);
      chk("bne_dropped_flush", {31'd0, flush}, 32'd0);
      chk("bne_miss_cnt", {28'd0, miss_cnt}, 32'd1);
      chk("bne_br_cnt", {28'd0, br_cnt}, 32'd2);
      if_valid = 1'b0;
      step();

      // beq taken, predicted not taken, negative offset
      load(32'h1FC, 1'b0);
      id_bne = 1'b0; id_beq = 1'b1; rs_data = 32'd9; rt_data = 32'd9; id_imm = 16'hFFFE;
      #1;
      chk("beq_neg_flush", {31'd0, flush}, 32'd1);
      chk("beq_neg_redirect", redirect_pc, 32'h1F8);
      step();
      chk("beq_neg_br_cnt", {28'd0, br_cnt}, 32'd3);
      chk("beq_neg_miss_cnt", {28'd0, miss_cnt}, 32'd2);

      // mispredicted beq held by three stall cycles
      load(32'h504, 1'b0);
      id_beq = 1'b1; rs_data = 32'd1; rt_data = 32'd1; id_imm = 16'd1;
      stall = 1'b1; if_valid = 1'b1; if_pc = 32'h900; if_BrPre = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_B", {31'd0, B}, 32'd0);
         chk("stall_prewrong", {31'd0, PreWrong}, 32'd0);
         chk("stall_flush", {31'd0, flush}, 32'd0);
         step();
      end
      chk("stall_br_cnt_hold", {28'd0, br_cnt}, 32'd3);
      stall = 1'b0;
      #1;
      chk("unstall_B", {31'd0, B}, 32'd1);
      chk("unstall_flush", {31'd0, flush}, 32'd1);
      chk("unstall_redirect", redirect_pc, 32'h50C);
      step();
      if_valid = 1'b0;
      chk("unstall_br_cnt", {28'd0, br_cnt}, 32'd4);
      chk("unstall_miss_cnt", {28'd0, miss_cnt}, 32'd3);
      chk("unstall_once_flush", {31'd0, flush}, 32'd0);

      // 20 further mispredicts drive both 4-bit counters into saturation
      for (int i = 0; i < 20; i++) begin
         load(32'h600, 1'b0);
         id_beq = 1'b1; rs_data = 32'd2; rt_data = 32'd2;
         step();
      end
      chk("sat_br_cnt", {28'd0, br_cnt}, 32'd15);
      chk("sat_miss_cnt", {28'd0, miss_cnt}, 32'd15);

      // async reset while a flush is asserted
      load(32'h700, 1'b0);
      #1;
      chk("pre_rst_flush", {31'd0, flush}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_flush", {31'd0, flush}, 32'd0);
      chk("async_rst_B", {31'd0, B}, 32'd0);
      chk("async_rst_prewrong", {31'd0, PreWrong}, 32'd0);
      chk("async_rst_br_cnt", {28'd0, br_cnt}, 32'd0);
      chk("async_rst_miss_cnt", {28'd0, miss_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
